// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM command/config generator.
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIV_PER,
        MUL_DUTY,
        DIV_DUTY,
        ARMED
    } fsm_e;

    localparam int DUTY_FULL    = 100;
    localparam int CMD_FREQ_BIT = 7;

    // Command byte: top bit selects frequency code vs duty percentage.
    typedef struct packed {
        logic                    is_freq;
        logic [CMD_FREQ_BIT-1:0] value;
    } cmd_t;

    function automatic logic [CMD_FREQ_BIT-1:0] clamp7(
        input logic [CMD_FREQ_BIT-1:0] v,
        input logic [CMD_FREQ_BIT-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/pwm_serdiv.sv
// Restoring serial divider, one quotient bit per clock; done pulses for one clock
// in the cycle the quotient becomes valid. Divisor must be non-zero.
module pwm_serdiv #(
    parameter int W = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_quotient,
    output logic         o_done
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_quo;
    logic [W:0]    r_rem;
    logic [W-1:0]  r_dvs;
    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          r_done;

    logic [W+1:0]  w_shift;
    logic [W+1:0]  w_diff;
    logic          w_neg;

    // Extra headroom bit keeps the trial-subtraction sign reliable.
    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_diff  = w_shift - {2'b00, r_dvs};
    assign w_neg   = w_diff[W+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_quo <= i_dividend;
                r_rem <= '0;
                r_dvs <= i_divisor;
                r_cnt <= CW'(W);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_rem <= w_neg ? w_shift[W:0] : w_diff[W:0];
                r_quo <= {r_quo[W-2:0], ~w_neg};
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_quotient = r_quo;
    assign o_done     = r_done;

endmodule

// File: rtl/pwm_cfg_gen.sv
// PWM generator configured by one-byte commands; period/compare computed with a shared
// serial divider and applied only at a period boundary. PWM_DEADTIME_EN adds a dead band.
module pwm_cfg_gen
    import pwm_pkg::*;
#(
    parameter int PRESCALE   = 50,
    parameter int PERIOD_NUM = 1000,
    parameter int FREQ_MAX   = 100,
    parameter int CNT_W      = 16,
    parameter int DEADTIME   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       busy,
    output logic [6:0] cur_freq,
    output logic [6:0] cur_duty,
    output logic       cmd_err,
    output logic       pwm1,
    output logic       pwm2
);
    localparam int               DW        = CNT_W + 7;
    localparam int               PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] PER_RESET = CNT_W'(PERIOD_NUM);
    localparam logic [6:0]       FREQ_LIM  = 7'(FREQ_MAX);
    localparam logic [6:0]       DUTY_LIM  = 7'(DUTY_FULL);

    fsm_e             r_state;
    fsm_e             w_state_next;

    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_cmp;
    logic [CNT_W-1:0] r_new_per;
    logic [CNT_W-1:0] r_new_cmp;
    logic [6:0]       r_pend_freq;
    logic [6:0]       r_pend_duty;
    logic [6:0]       r_cur_freq;
    logic [6:0]       r_cur_duty;
    logic             r_err;

    cmd_t             w_cmd;
    logic             w_ready;
    logic             w_cmd_acc;
    logic             w_freq_zero;
    logic             w_accept;
    logic [6:0]       w_pend_freq_next;
    logic [6:0]       w_pend_duty_next;
    logic             w_tick;
    logic             w_wrap;
    logic             w_apply;
    logic             w_raw_next;
    logic [DW-1:0]    w_prod;

    logic             w_div_start;
    logic [DW-1:0]    w_div_dividend;
    logic [DW-1:0]    w_div_divisor;
    logic [DW-1:0]    w_div_quo;
    logic             w_div_done;

    // ---------------- command decode ----------------
    assign w_cmd       = cmd_t'(cmd_data);
    assign w_ready     = (r_state == IDLE) || (r_state == ARMED);
    assign w_cmd_acc   = cmd_valid && w_ready;
    assign w_freq_zero = w_cmd.is_freq && (w_cmd.value == 7'd0);
    assign w_accept    = w_cmd_acc && !w_freq_zero;

    // Each command touches only its own field; the divider sees the updated value directly.
    assign w_pend_freq_next = (w_accept && w_cmd.is_freq)
                            ? clamp7(w_cmd.value, FREQ_LIM) : r_pend_freq;
    assign w_pend_duty_next = (w_accept && !w_cmd.is_freq)
                            ? clamp7(w_cmd.value, DUTY_LIM) : r_pend_duty;

    assign w_prod = {7'd0, r_new_per} * {{(DW-7){1'b0}}, r_pend_duty};

    // ---------------- timebase ----------------
    assign w_tick     = (r_pre == PRE_LAST);
    assign w_wrap     = w_tick && (r_cnt == r_per - 1'b1);
    assign w_raw_next = (r_cnt < r_cmp);

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_div_start    = 1'b0;
        w_div_dividend = DW'(PERIOD_NUM);
        w_div_divisor  = {{(DW-7){1'b0}}, w_pend_freq_next};
        w_apply        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_div_start  = 1'b1;
                    w_state_next = DIV_PER;
                end
            end
            DIV_PER: begin
                if (w_div_done) begin
                    w_state_next = MUL_DUTY;
                end
            end
            MUL_DUTY: begin
                w_div_start    = 1'b1;
                w_div_dividend = w_prod;
                w_div_divisor  = DW'(DUTY_FULL);
                w_state_next   = DIV_DUTY;
            end
            DIV_DUTY: begin
                if (w_div_done) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                // A fresh command beats a coincident wrap: the armed result is stale.
                if (w_accept) begin
                    w_div_start  = 1'b1;
                    w_state_next = DIV_PER;
                end else if (w_wrap) begin
                    w_apply      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    pwm_serdiv #(
        .W (DW)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_div_dividend),
        .i_divisor  (w_div_divisor),
        .o_quotient (w_div_quo),
        .o_done     (w_div_done)
    );

    // ---------------- configuration registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_freq <= 7'd1;
            r_pend_duty <= 7'd0;
            r_new_per   <= PER_RESET;
            r_new_cmp   <= '0;
            r_per       <= PER_RESET;
            r_cmp       <= '0;
            r_cur_freq  <= 7'd1;
            r_cur_duty  <= 7'd0;
            r_err       <= 1'b0;
        end else begin
            r_pend_freq <= w_pend_freq_next;
            r_pend_duty <= w_pend_duty_next;
            if (cmd_valid && !w_ready) begin
                r_err <= 1'b1;
            end
            if (w_cmd_acc && w_freq_zero) begin
                r_err <= 1'b1;
            end
            if (r_state == DIV_PER && w_div_done) begin
                r_new_per <= (w_div_quo == '0) ? CNT_W'(1) : w_div_quo[CNT_W-1:0];
            end
            if (r_state == DIV_DUTY && w_div_done) begin
                r_new_cmp <= w_div_quo[CNT_W-1:0];
            end
            if (w_apply) begin
                r_per      <= r_new_per;
                r_cmp      <= r_new_cmp;
                r_cur_freq <= r_pend_freq;
                r_cur_duty <= r_pend_duty;
            end
        end
    end

    // Apply lands on the wrap edge, so the counter restarts at 0 under the new period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
`ifdef PWM_DEADTIME_EN
    // Dead band is held in clocks (DEADTIME ticks); each rising edge waits it out.
    localparam int              DT_CLK  = DEADTIME * PRESCALE;
    localparam int              DT_W    = (DT_CLK > 0) ? $clog2(DT_CLK + 1) : 1;
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DT_CLK);

    logic            r_raw;
    logic [DT_W-1:0] r_dt;
    logic            r_pwm1;
    logic            r_pwm2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw  <= 1'b0;
            r_dt   <= '0;
            r_pwm1 <= 1'b0;
            r_pwm2 <= 1'b0;
        end else begin
            r_raw <= w_raw_next;
            if (w_raw_next != r_raw) begin
                r_dt <= '0;
            end else if (r_dt != DT_LAST) begin
                r_dt <= r_dt + 1'b1;
            end
            r_pwm1 <= r_raw && (r_dt == DT_LAST);
            r_pwm2 <= !r_raw && (r_dt == DT_LAST);
        end
    end

    assign pwm1 = r_pwm1;
    assign pwm2 = r_pwm2;
`else
    logic r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_raw_next;
        end
    end

    // Without a dead band both pads carry the same register; a negative dead band is meaningless.
    if (DEADTIME >= 0) begin : g_out
        assign pwm1 = r_pwm;
        assign pwm2 = r_pwm;
    end else begin : g_out_bad
        assign pwm1 = 1'b0;
        assign pwm2 = 1'b0;
    end
`endif

    assign cmd_ready = w_ready;
    assign busy      = !w_ready;
    assign cur_freq  = r_cur_freq;
    assign cur_duty  = r_cur_duty;
    assign cmd_err   = r_err;

endmodule
